// File: rtl/aha_ahb_sram_pkg.sv
// Shared AHB encodings and byte-lane helpers for the AHB-to-SRAM bridge.
package aha_ahb_sram_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_t;

  localparam int LANES = 4;

  // Any size encoding above a word is handled as a full word.
  function automatic logic [LANES-1:0] byte_mask(input logic [2:0] hsize,
                                                 input logic [1:0] addr_lo);
    logic [LANES-1:0] m;
    case (hsize)
      HSIZE_BYTE: m = 4'b0001 << addr_lo;
      HSIZE_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [LANES-1:0] mask,
                                              input logic [31:0] new_data,
                                              input logic [31:0] old_data);
    logic [31:0] r;
    for (int i = 0; i < LANES; i++) begin
      r[8*i +: 8] = mask[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/aha_ahb_sram_wbuf.sv
// One-entry posted write buffer with read-after-write byte forwarding.
module aha_ahb_sram_wbuf
  import aha_ahb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [LANES-1:0]      load_mask,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  drain,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  valid,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [LANES-1:0]      mask,
  output logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] fwd_data
);

  logic hit;

  // A load wins over a drain at the same edge so a new entry is never dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      addr  <= '0;
      mask  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      mask  <= load_mask;
      data  <= load_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  assign hit      = valid && (addr == rd_addr);
  assign fwd_data = hit ? merge_bytes(mask, data, sram_rdata) : sram_rdata;

endmodule

// File: rtl/aha_ahb_sram_bridge.sv
// Zero-wait-state AHB-Lite slave in front of a single-port 32-bit SRAM,
// with a posted write buffer so write data can arrive in the data phase.
module aha_ahb_sram_bridge
  import aha_ahb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic                  HREADY,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  SRAMCEn,
  output logic [LANES-1:0]      SRAMWEn,
  output logic [ADDR_WIDTH-1:0] SRAMADDR,
  output logic [DATA_WIDTH-1:0] SRAMWDATA,
  input  logic [DATA_WIDTH-1:0] SRAMRDATA
);

  logic                  accept, acc_rd, acc_wr;
  logic                  wr_dp, rd_dp;
  logic [ADDR_WIDTH-1:0] dp_addr;
  logic [LANES-1:0]      dp_mask;
  logic [ADDR_WIDTH-1:0] held_addr;
  logic [DATA_WIDTH-1:0] held_wdata;
  logic                  buf_valid, drain;
  logic [ADDR_WIDTH-1:0] buf_addr;
  logic [LANES-1:0]      buf_mask;
  logic [DATA_WIDTH-1:0] buf_data, fwd_data;
  logic                  unused_bits;

  assign HREADYOUT   = 1'b1;
  assign HRESP       = 1'b0;
  assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  assign accept = HSEL & HREADY & HTRANS[1];
  assign acc_rd = accept & ~HWRITE;
  assign acc_wr = accept & HWRITE;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_dp   <= 1'b0;
      rd_dp   <= 1'b0;
      dp_addr <= '0;
      dp_mask <= '0;
    end else if (HREADY) begin
      wr_dp   <= acc_wr;
      rd_dp   <= acc_rd;
      dp_addr <= HADDR[ADDR_WIDTH+1:2];
      dp_mask <= byte_mask(HSIZE, HADDR[1:0]);
    end
  end

  // Reads go straight to the SRAM; the buffer only uses cycles with no read.
  assign drain = buf_valid & ~acc_rd & ~RESET;

  aha_ahb_sram_wbuf #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_wbuf (
    .clk        (CLK),
    .reset      (RESET),
    .load       (wr_dp),
    .load_addr  (dp_addr),
    .load_mask  (dp_mask),
    .load_data  (HWDATA),
    .drain      (drain),
    .rd_addr    (dp_addr),
    .sram_rdata (SRAMRDATA),
    .valid      (buf_valid),
    .addr       (buf_addr),
    .mask       (buf_mask),
    .data       (buf_data),
    .fwd_data   (fwd_data)
  );

  always_comb begin
    SRAMCEn   = 1'b1;
    SRAMWEn   = '1;
    SRAMADDR  = held_addr;
    SRAMWDATA = held_wdata;
    if (RESET) begin
      SRAMADDR  = '0;
      SRAMWDATA = '0;
    end else if (acc_rd) begin
      SRAMCEn  = 1'b0;
      SRAMADDR = HADDR[ADDR_WIDTH+1:2];
    end else if (buf_valid) begin
      SRAMCEn   = 1'b0;
      SRAMWEn   = ~buf_mask;
      SRAMADDR  = buf_addr;
      SRAMWDATA = buf_data;
    end
  end

  // Idle cycles replay the last address and data to avoid needless toggling.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      held_addr  <= '0;
      held_wdata <= '0;
    end else begin
      held_addr  <= SRAMADDR;
      held_wdata <= SRAMWDATA;
    end
  end

  assign HRDATA = (rd_dp && !RESET) ? fwd_data : '0;

endmodule

// File: doc/aha_ahb_sram_bridge.md
Name: aha_ahb_sram_bridge

Overview:
AHB-Lite slave that fronts the 32K-by-32 SRAM wrapper (128 KB, CEn/WEn[3:0]/A[14:0]/D/Q, one-cycle registered read), directly upstream of it.
- Converts zero-wait-state AHB byte, halfword and word transfers into single-port SRAM accesses.
- Uses a one-entry posted write buffer, because AHB write data arrives one cycle after the address.
- Read-after-write data is forwarded by byte-merging the buffer contents into SRAM read data.

Parameters:
ADDR_WIDTH, 15, SRAM word-address width; the SRAM address is HADDR[ADDR_WIDTH+1:2].
DATA_WIDTH, 32, bus and SRAM data width; fixed at 32, with byte lanes = DATA_WIDTH/8.

Ports:
CLK  in  1  clock.
RESET  in  1  synchronous, active-high reset.
HSEL  in  1  slave select.
HADDR  in  32  byte address; bits above ADDR_WIDTH+1 are ignored.
HTRANS  in  2  transfer type; NONSEQ=2'b10, SEQ=2'b11 are active.
HSIZE  in  3  0=byte, 1=half, 2=word; values above 2 are treated as word.
HWRITE  in  1  1=write.
HREADY  in  1  bus ready; the address phase is sampled only when this is high.
HWDATA  in  32  write data, valid in the data phase.
HREADYOUT  out  1  constant 1 (zero wait states).
HRESP  out  1  constant 0 (OKAY).
HRDATA  out  32  read data, valid in the read data phase.
SRAMCEn  out  1  SRAM chip enable, active low.
SRAMWEn  out  4  per-byte write enable, active low; 4'hF means read.
SRAMADDR  out  ADDR_WIDTH  SRAM word address.
SRAMWDATA  out  32  SRAM write data.
SRAMRDATA  in  32  SRAM Q, valid the cycle after a read enable.

Behaviour:
- Accept = HSEL & HREADY & HTRANS[1]. An accepted read is acc_rd; an accepted write is acc_wr.
- Byte mask is derived from HSIZE and HADDR[1:0]:
  - byte: 4'b0001 << HADDR[1:0];
  - half: HADDR[1] ? 4'b1100 : 4'b0011;
  - word: 4'hF.
- Data-phase registers, loaded on every cycle where HREADY=1:
  - wr_dp = acc_wr, with the address/mask captured;
  - rd_dp = acc_rd, with the address captured.
- Write buffer (buf_valid, buf_addr, buf_mask, buf_data):
  - Load at the end of a cycle with wr_dp=1, using HWDATA and the captured address/mask.
  - Drain whenever buf_valid=1 and acc_rd=0: SRAMCEn=0, SRAMWEn=~buf_mask, SRAMADDR=buf_addr, SRAMWDATA=buf_data. buf_valid clears at the edge unless it reloads at the same edge.
  - Invariant: the address-phase cycle of any write has no read, so the buffer always drains then. A load therefore never overwrites an undrained entry; a bench assertion checks this.
- SRAM port priority:
  - acc_rd: SRAMCEn=0, SRAMWEn=4'hF, SRAMADDR=HADDR[ADDR_WIDTH+1:2], issued in the same cycle (combinational).
  - Else the buffer drains.
  - Else idle: SRAMCEn=1, SRAMWEn=4'hF; SRAMADDR and SRAMWDATA hold their previous values.
- Read data:
  - Read latency is one cycle; HRDATA is driven in the cycle where rd_dp=1.
  - If buf_valid and buf_addr == rd_dp address, then for each byte with buf_mask=1, HRDATA takes the buf_data byte; all other bytes take SRAMRDATA.
  - When rd_dp=0, HRDATA = 0.
- Write data phase overlapping a read address phase: the read goes to the SRAM and the write is buffered. Write-then-read to the same word forwards correctly.
- Back-to-back writes: each write drains during the next write's address phase. Writes are never reordered or lost.
- IDLE/BUSY transfers, and cycles with HSEL=0, do not create new data phases. A pending buffer still drains during them.
- On RESET:
  - buf_valid=0; a pending, undrained write is discarded by design.
  - wr_dp=0, rd_dp=0.
  - SRAMCEn=1, SRAMWEn=4'hF, SRAMADDR=0, SRAMWDATA=0, HRDATA=0.
  - HREADYOUT=1 and HRESP=0 in all cycles, including during reset.
- Address wrap: addresses alias modulo 2^(ADDR_WIDTH+2) bytes.

Decomposition:
- Package aha_ahb_sram_pkg holds:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ);
  - HSIZE encodings;
  - the function byte_mask(hsize, addr_lo) returning 4 bits;
  - the function merge_bytes(mask, new, old).
- Sub-module aha_ahb_sram_wbuf holds the buffer registers, load/drain control and the forwarding merge. The top level keeps the AHB phase registers and the SRAM port mux.

Test Plan:
- Word write 0x20000010 = 0xDEADBEEF, idle, then read 0x20000010 -> SRAM write (SRAMADDR=15'h0004, SRAMWEn=4'h0) in the idle cycle; HRDATA=0xDEADBEEF one cycle after the read address.
- Byte write 0xAB to byte address 0x13, immediately followed by a word read of 0x10 (no idle), with SRAM word = 0x11223344 -> read issued first; HRDATA=0xAB223344 via forwarding; the buffer drains afterwards with SRAMWEn=4'b0111.
- Halfword write 0xCAFE to 0x102, then 0x1234 to 0x100, back-to-back -> drains in order, with WEn=4'b0011 then WEn=4'b1100. Final word read = 0xCAFE1234.
- Stream of 8 back-to-back word reads to 0x0..0x1C with a write pending -> write drains only after the read stream ends; every HRDATA matches memory and HREADYOUT stays 1.
- RESET asserted in the cycle after a write data phase (buffer valid) -> SRAMCEn=1 that cycle; no SRAM write occurs; a later read returns the old value.
- HTRANS=BUSY with HSEL=1, and HSEL=0 with HTRANS=NONSEQ -> no data phase and HRDATA=0; a pending buffer still drains in these cycles.
